// File: rtl/isp_ccm_pkg.sv
// Shared definitions for the colour-correction matrix stage: coefficient format,
// register map, identity matrix and the commit controller state encoding.
package isp_ccm_pkg;

  localparam int COEF_W    = 8;
  localparam int FRAC_BITS = 4;
  localparam int NUM_COEF  = 9;

  localparam logic [3:0] ADDR_COEF_LAST = 4'd8;
  localparam logic [3:0] ADDR_CTRL      = 4'd9;
  localparam logic [3:0] ADDR_STATUS    = 4'd10;

  localparam logic [71:0] CCM_IDENTITY = 72'h10_00_00_00_10_00_00_00_10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    APPLY = 2'd2
  } ccm_state_e;

endpackage

// File: rtl/isp_edge_det.sv
// Single-register capture of a level input with a rising-edge pulse taken
// from the captured copy and its delayed copy.
module isp_edge_det (
  input  logic pclk,
  input  logic rst_n,
  input  logic sig_i,
  output logic rise_o
);

  logic sig_q, sig_qq;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q  <= 1'b0;
      sig_qq <= 1'b0;
    end else begin
      sig_q  <= sig_i;
      sig_qq <= sig_q;
    end
  end

  assign rise_o = sig_q & ~sig_qq;

endmodule

// File: rtl/isp_ccm_ctrl.sv
// CCM configuration controller: host-writable shadow bank, committed atomically
// into the active bank on a frame boundary (or after an optional timeout).
module isp_ccm_ctrl
  import isp_ccm_pkg::*;
#(
  parameter int COEF_W      = isp_ccm_pkg::COEF_W,
  parameter int TIMEOUT_CYC = 0,
  parameter int FCNT_W      = 16
) (
  input  logic                  pclk,
  input  logic                  rst_n,
  input  logic                  cfg_we,
  input  logic [3:0]            cfg_addr,
  input  logic [COEF_W-1:0]     cfg_wdata,
  output logic [COEF_W-1:0]     cfg_rdata,
  input  logic                  cfg_commit,
  input  logic                  in_vsync,
  output logic                  commit_pend,
  output logic                  commit_done,
  output logic [9*COEF_W-1:0]   ccm_coef,
  output logic                  ccm_bypass,
  output logic [FCNT_W-1:0]     frame_cnt
);

  localparam logic [COEF_W-1:0]   ONE   = COEF_W'(1 << FRAC_BITS);
  localparam logic [3*COEF_W-1:0] ZERO3 = '0;
  localparam logic [NUM_COEF-1:0][COEF_W-1:0] IDENT = {ONE, ZERO3, ONE, ZERO3, ONE};
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TLIM = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  ccm_state_e                        state_q;
  logic [TW-1:0]                     tcnt_q;
  logic [NUM_COEF-1:0][COEF_W-1:0]   shadow_q, active_q;
  logic                              sh_byp_q, act_byp_q;
  logic                              done_q;
  logic [COEF_W-1:0]                 rdata_q, rdata_d;
  logic [FCNT_W-1:0]                 fcnt_q;
  logic                              vs_rise, timeout_hit, is_coef;
  logic [3:0]                        cidx;

  isp_edge_det u_vs_det (
    .pclk   (pclk),
    .rst_n  (rst_n),
    .sig_i  (in_vsync),
    .rise_o (vs_rise)
  );

  // Address 0 (rr) lives in the top slot so the packed bank is rr-first.
  assign is_coef     = (cfg_addr <= ADDR_COEF_LAST);
  assign cidx        = 4'(NUM_COEF - 1) - cfg_addr;
  assign timeout_hit = (TIMEOUT_CYC != 0) && (tcnt_q == TLIM);

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= IDENT;
      sh_byp_q <= 1'b0;
    end else if (cfg_we) begin
      if (is_coef)                    shadow_q[cidx] <= cfg_wdata;
      else if (cfg_addr == ADDR_CTRL) sh_byp_q       <= cfg_wdata[0];
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tcnt_q    <= '0;
      active_q  <= IDENT;
      act_byp_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        // A commit coinciding with a frame edge waits for the next one.
        IDLE: if (cfg_commit) begin
          state_q <= PEND;
          tcnt_q  <= '0;
        end
        PEND: if (vs_rise || timeout_hit) state_q <= APPLY;
              else                        tcnt_q  <= tcnt_q + TW'(1);
        APPLY: begin
          active_q  <= shadow_q;
          act_byp_q <= sh_byp_q;
          done_q    <= 1'b1;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n)       fcnt_q <= '0;
    else if (vs_rise) fcnt_q <= fcnt_q + FCNT_W'(1);
  end

  always_comb begin
    rdata_d = '0;
    if (is_coef)                      rdata_d = shadow_q[cidx];
    else if (cfg_addr == ADDR_CTRL)   rdata_d = COEF_W'(sh_byp_q);
    else if (cfg_addr == ADDR_STATUS) rdata_d = COEF_W'({commit_pend, act_byp_q});
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign commit_pend = (state_q != IDLE);
  assign commit_done = done_q;
  assign ccm_coef    = active_q;
  assign ccm_bypass  = act_byp_q;
  assign frame_cnt   = fcnt_q;
  assign cfg_rdata   = rdata_q;

endmodule
